// File: rtl/cop_issue_ctrl.sv
// rtl/cop_issue_ctrl.sv - core-side Check/Ready/Exec issue controller for one coprocessor
module cop_issue_ctrl #(
    parameter bit FWD_EN     = 1'b1,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HOLD,
    input  logic        FLUSH,
    input  logic        D_VALID,
    input  logic [31:0] D_PC,
    input  logic [16:0] D_OPCODE,
    input  logic [4:0]  D_RD,
    input  logic [4:0]  D_RS1,
    input  logic [4:0]  D_RS2,
    input  logic [31:0] D_IMM,
    output logic        D_READY,
    output logic        D_REJECT,
    output logic [16:0] C_OPCODE,
    input  logic        C_ACCEPT,
    output logic [16:0] R_OPCODE,
    output logic [4:0]  R_RD,
    output logic [4:0]  R_RS1,
    output logic [4:0]  R_RS2,
    output logic [31:0] R_IMM,
    output logic [4:0]  RF_RS1,
    output logic [4:0]  RF_RS2,
    input  logic [31:0] RF_RS1_DATA,
    input  logic [31:0] RF_RS2_DATA,
    output logic        E_ALLOW,
    output logic [31:0] E_PC,
    output logic [16:0] E_OPCODE,
    output logic [4:0]  E_RD,
    output logic [4:0]  E_RS1,
    output logic [31:0] E_RS1_DATA,
    output logic [4:0]  E_RS2,
    output logic [31:0] E_RS2_DATA,
    output logic [31:0] E_IMM,
    input  logic        E_VALID,
    input  logic        E_REG_W_EN,
    input  logic [4:0]  E_REG_W_RD,
    input  logic [31:0] E_REG_W_DATA,
    input  logic        E_EXC_EN,
    input  logic [3:0]  E_EXC_CODE,
    output logic        W_EN,
    output logic [4:0]  W_RD,
    output logic [31:0] W_DATA,
    output logic        X_EN,
    output logic [31:0] X_PC,
    output logic [3:0]  X_CODE,
    output logic        ERR
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [16:0] r_opcode;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [31:0] r_imm;

    logic        e_valid;
    logic [31:0] e_pc;
    logic [16:0] e_opcode;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [31:0] e_rs1_data, e_rs2_data, e_imm;

    logic        w_en;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        x_en;
    logic [31:0] x_pc;
    logic [3:0]  x_code;
    logic        err;

    logic        check_ok;
    logic        kill;
    logic        advance_e;
    logic        err_evt;
    logic        fwd_e_en, fwd_w_en;
    logic [31:0] op1, op2;

    assign check_ok  = D_VALID && !HOLD && !FLUSH;
    assign C_OPCODE  = check_ok ? D_OPCODE : 17'd0;
    assign E_ALLOW   = e_valid && !FLUSH;
    // An excepting Exec instruction squashes everything younger, including this cycle's issue.
    assign kill      = E_ALLOW && E_VALID && E_EXC_EN;
    assign D_READY   = check_ok && C_ACCEPT && !kill;
    assign D_REJECT  = D_VALID && !HOLD && !C_ACCEPT;
    assign advance_e = r_valid && !FLUSH && !kill;
    assign err_evt   = (E_ALLOW && !E_VALID) || (E_VALID && !e_valid);

    assign fwd_e_en  = FWD_EN && E_VALID && E_REG_W_EN;
    assign fwd_w_en  = FWD_EN && w_en;

    // The E-stage result is younger than the W-stage one, so it takes priority.
    function automatic logic [31:0] fwd_sel(input logic [4:0] rs, input logic [31:0] rf_d);
        if (fwd_e_en && rs != 5'd0 && E_REG_W_RD == rs) begin
            return E_REG_W_DATA;
        end else if (fwd_w_en && rs != 5'd0 && w_rd == rs) begin
            return w_data;
        end else begin
            return rf_d;
        end
    endfunction

    always_comb begin
        op1 = fwd_sel(r_rs1, RF_RS1_DATA);
        op2 = fwd_sel(r_rs2, RF_RS2_DATA);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_opcode   <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            e_valid    <= 1'b0;
            e_pc       <= '0;
            e_opcode   <= '0;
            e_rd       <= '0;
            e_rs1      <= '0;
            e_rs2      <= '0;
            e_rs1_data <= '0;
            e_rs2_data <= '0;
            e_imm      <= '0;
            w_en       <= 1'b0;
            w_rd       <= '0;
            w_data     <= '0;
            x_en       <= 1'b0;
            x_pc       <= '0;
            x_code     <= '0;
            err        <= 1'b0;
        end else begin
            r_valid <= D_READY;
            if (D_READY) begin
                r_pc     <= D_PC;
                r_opcode <= D_OPCODE;
                r_rd     <= D_RD;
                r_rs1    <= D_RS1;
                r_rs2    <= D_RS2;
                r_imm    <= D_IMM;
            end else begin
                r_pc     <= '0;
                r_opcode <= '0;
                r_rd     <= '0;
                r_rs1    <= '0;
                r_rs2    <= '0;
                r_imm    <= '0;
            end

            e_valid <= advance_e;
            if (advance_e) begin
                e_pc       <= r_pc;
                e_opcode   <= r_opcode;
                e_rd       <= r_rd;
                e_rs1      <= r_rs1;
                e_rs2      <= r_rs2;
                e_rs1_data <= op1;
                e_rs2_data <= op2;
                e_imm      <= r_imm;
            end else begin
                e_pc       <= '0;
                e_opcode   <= '0;
                e_rd       <= '0;
                e_rs1      <= '0;
                e_rs2      <= '0;
                e_rs1_data <= '0;
                e_rs2_data <= '0;
                e_imm      <= '0;
            end

            w_en   <= E_ALLOW && E_VALID && E_REG_W_EN && !E_EXC_EN;
            w_rd   <= E_REG_W_RD;
            w_data <= E_REG_W_DATA;
            x_en   <= E_ALLOW && E_VALID && E_EXC_EN;
            x_pc   <= e_pc;
            x_code <= E_EXC_CODE;
            err    <= ERR_STICKY ? (err || err_evt) : err_evt;
        end
    end

    assign R_OPCODE   = r_opcode;
    assign R_RD       = r_rd;
    assign R_RS1      = r_rs1;
    assign R_RS2      = r_rs2;
    assign R_IMM      = r_imm;
    assign RF_RS1     = r_rs1;
    assign RF_RS2     = r_rs2;
    assign E_PC       = e_pc;
    assign E_OPCODE   = e_opcode;
    assign E_RD       = e_rd;
    assign E_RS1      = e_rs1;
    assign E_RS1_DATA = e_rs1_data;
    assign E_RS2      = e_rs2;
    assign E_RS2_DATA = e_rs2_data;
    assign E_IMM      = e_imm;
    assign W_EN       = w_en;
    assign W_RD       = w_rd;
    assign W_DATA     = w_data;
    assign X_EN       = x_en;
    assign X_PC       = x_pc;
    assign X_CODE     = x_code;
    assign ERR        = err;

endmodule

// File: tb/tb_cop_issue_ctrl.sv
// tb/tb_cop_issue_ctrl.sv - randomized bench for cop_issue_ctrl with stub cop and program-order model
module tb_cop_issue_ctrl;

    localparam logic [16:0] OP_ADDI = {7'b0010011, 3'b000, 7'b0000000};
    localparam logic [16:0] OP_ADD  = {7'b0110011, 3'b000, 7'b0000000};
    localparam logic [16:0] OP_TRAP = {7'b0110011, 3'b000, 7'b0100000};
    localparam logic [16:0] OP_LOAD = {7'b0000011, 3'b010, 7'b0000000};

    logic        CLK = 1'b0;
    logic        RST, HOLD, FLUSH, D_VALID;
    logic [31:0] D_PC, D_IMM;
    logic [16:0] D_OPCODE;
    logic [4:0]  D_RD, D_RS1, D_RS2;
    logic        D_READY, D_REJECT, C_ACCEPT;
    logic [16:0] C_OPCODE, R_OPCODE, E_OPCODE;
    logic [4:0]  R_RD, R_RS1, R_RS2, RF_RS1, RF_RS2;
    logic [31:0] R_IMM, RF_RS1_DATA, RF_RS2_DATA;
    logic        E_ALLOW;
    logic [31:0] E_PC, E_RS1_DATA, E_RS2_DATA, E_IMM;
    logic [4:0]  E_RD, E_RS1, E_RS2;
    logic        E_VALID, E_REG_W_EN, E_EXC_EN;
    logic [4:0]  E_REG_W_RD;
    logic [31:0] E_REG_W_DATA;
    logic [3:0]  E_EXC_CODE;
    logic        W_EN, X_EN, ERR;
    logic [4:0]  W_RD;
    logic [31:0] W_DATA, X_PC;
    logic [3:0]  X_CODE;

    cop_issue_ctrl dut (
        .CLK(CLK), .RST(RST), .HOLD(HOLD), .FLUSH(FLUSH),
        .D_VALID(D_VALID), .D_PC(D_PC), .D_OPCODE(D_OPCODE), .D_RD(D_RD),
        .D_RS1(D_RS1), .D_RS2(D_RS2), .D_IMM(D_IMM),
        .D_READY(D_READY), .D_REJECT(D_REJECT),
        .C_OPCODE(C_OPCODE), .C_ACCEPT(C_ACCEPT),
        .R_OPCODE(R_OPCODE), .R_RD(R_RD), .R_RS1(R_RS1), .R_RS2(R_RS2), .R_IMM(R_IMM),
        .RF_RS1(RF_RS1), .RF_RS2(RF_RS2), .RF_RS1_DATA(RF_RS1_DATA), .RF_RS2_DATA(RF_RS2_DATA),
        .E_ALLOW(E_ALLOW), .E_PC(E_PC), .E_OPCODE(E_OPCODE), .E_RD(E_RD),
        .E_RS1(E_RS1), .E_RS1_DATA(E_RS1_DATA), .E_RS2(E_RS2), .E_RS2_DATA(E_RS2_DATA),
        .E_IMM(E_IMM),
        .E_VALID(E_VALID), .E_REG_W_EN(E_REG_W_EN), .E_REG_W_RD(E_REG_W_RD),
        .E_REG_W_DATA(E_REG_W_DATA), .E_EXC_EN(E_EXC_EN), .E_EXC_CODE(E_EXC_CODE),
        .W_EN(W_EN), .W_RD(W_RD), .W_DATA(W_DATA),
        .X_EN(X_EN), .X_PC(X_PC), .X_CODE(X_CODE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stub cop: implements addi, add and a trapping op; everything else is refused.
    function automatic bit f_addi(input logic [16:0] op);
        return op[16:7] == OP_ADDI[16:7];
    endfunction
    function automatic bit f_trap(input logic [16:0] op);
        return op == OP_TRAP;
    endfunction
    function automatic bit f_acc(input logic [16:0] op);
        return f_addi(op) || op == OP_ADD || f_trap(op);
    endfunction

    logic drop = 1'b0;
    assign C_ACCEPT     = f_acc(C_OPCODE);
    assign E_VALID      = E_ALLOW && !drop;
    assign E_EXC_EN     = E_VALID && f_trap(E_OPCODE);
    assign E_EXC_CODE   = 4'd2;
    assign E_REG_W_EN   = E_VALID && !f_trap(E_OPCODE);
    assign E_REG_W_RD   = E_RD;
    assign E_REG_W_DATA = f_addi(E_OPCODE) ? E_RS1_DATA + E_IMM : E_RS1_DATA + E_RS2_DATA;

    logic [31:0] rf_env [32] = '{default: 32'd0};
    always @(posedge CLK) if (W_EN && W_RD != 5'd0) rf_env[W_RD] <= W_DATA;
    assign RF_RS1_DATA = (RF_RS1 == 5'd0) ? 32'd0 : rf_env[RF_RS1];
    assign RF_RS2_DATA = (RF_RS2 == 5'd0) ? 32'd0 : rf_env[RF_RS2];

    // Model: instructions in program order tagged with their issue cycle; architectural regs.
    typedef struct {
        logic [31:0] pc;
        logic [16:0] op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        int          cyc;
        bit          alive;
    } ins_t;
    ins_t q[$];
    logic [31:0] rf_m [32] = '{default: 32'd0};

    bit          cur_w_en = 0, cur_x_en = 0, cur_err = 0;
    logic [4:0]  cur_w_rd;
    logic [31:0] cur_w_data, cur_x_pc;
    bit          nxt_w_en, nxt_x_en, nxt_err;
    logic [4:0]  nxt_w_rd;
    logic [31:0] nxt_w_data, nxt_x_pc;
    int          ex_i, rd_i;
    bit          ex_live, ex_act, m_kill, c_ok, exp_rdy;
    logic [16:0] exp_c;
    logic [31:0] a1, a2, res;
    ins_t        ni;

    always @(negedge CLK) begin
        if (!RST) begin
            q.delete();
            cur_w_en = 0;
            cur_x_en = 0;
            cur_err  = 0;
            chk("rst_w_en", {31'd0, W_EN}, 32'd0);
            chk("rst_x_en", {31'd0, X_EN}, 32'd0);
            chk("rst_e_allow", {31'd0, E_ALLOW}, 32'd0);
            chk("rst_err", {31'd0, ERR}, 32'd0);
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc - 2) q.delete(0);
            ex_i = -1;
            rd_i = -1;
            foreach (q[i]) begin
                if (q[i].cyc == cyc - 2) ex_i = i;
                if (q[i].cyc == cyc - 1) rd_i = i;
            end

            chk("w_en", {31'd0, W_EN}, {31'd0, cur_w_en});
            if (cur_w_en) begin
                chk("w_rd", {27'd0, W_RD}, {27'd0, cur_w_rd});
                chk("w_data", W_DATA, cur_w_data);
                if (cur_w_rd != 5'd0) rf_m[cur_w_rd] = cur_w_data;
            end
            chk("x_en", {31'd0, X_EN}, {31'd0, cur_x_en});
            if (cur_x_en) begin
                chk("x_pc", X_PC, cur_x_pc);
                chk("x_code", {28'd0, X_CODE}, 32'd2);
            end
            chk("err", {31'd0, ERR}, {31'd0, cur_err});

            ex_live  = ex_i >= 0 && q[ex_i].alive;
            ex_act   = ex_live && !FLUSH;
            nxt_w_en = 0;
            nxt_x_en = 0;
            nxt_w_rd = 0;
            nxt_w_data = 0;
            nxt_x_pc = 0;
            m_kill   = 0;
            nxt_err  = cur_err || (ex_act && drop);
            chk("e_allow", {31'd0, E_ALLOW}, {31'd0, ex_act});
            if (ex_live) begin
                a1  = (q[ex_i].rs1 == 5'd0) ? 32'd0 : rf_m[q[ex_i].rs1];
                a2  = (q[ex_i].rs2 == 5'd0) ? 32'd0 : rf_m[q[ex_i].rs2];
                res = f_addi(q[ex_i].op) ? a1 + q[ex_i].imm : a1 + a2;
                chk("e_pc", E_PC, q[ex_i].pc);
                chk("e_opcode", {15'd0, E_OPCODE}, {15'd0, q[ex_i].op});
                chk("e_rd", {27'd0, E_RD}, {27'd0, q[ex_i].rd});
                chk("e_rs1", {27'd0, E_RS1}, {27'd0, q[ex_i].rs1});
                chk("e_rs2", {27'd0, E_RS2}, {27'd0, q[ex_i].rs2});
                chk("e_imm", E_IMM, q[ex_i].imm);
                chk("e_rs1_data", E_RS1_DATA, a1);
                chk("e_rs2_data", E_RS2_DATA, a2);
                if (ex_act && !drop) begin
                    if (f_trap(q[ex_i].op)) begin
                        nxt_x_en = 1;
                        nxt_x_pc = q[ex_i].pc;
                        m_kill   = 1;
                    end else begin
                        nxt_w_en   = 1;
                        nxt_w_rd   = q[ex_i].rd;
                        nxt_w_data = res;
                    end
                end
            end

            if (rd_i >= 0 && q[rd_i].alive) begin
                chk("r_opcode", {15'd0, R_OPCODE}, {15'd0, q[rd_i].op});
                chk("r_rd", {27'd0, R_RD}, {27'd0, q[rd_i].rd});
                chk("rf_rs1", {27'd0, RF_RS1}, {27'd0, q[rd_i].rs1});
                chk("rf_rs2", {27'd0, RF_RS2}, {27'd0, q[rd_i].rs2});
                chk("r_imm", R_IMM, q[rd_i].imm);
                if (FLUSH || m_kill) q[rd_i].alive = 0;
            end

            c_ok    = D_VALID && !HOLD && !FLUSH;
            exp_c   = c_ok ? D_OPCODE : 17'd0;
            exp_rdy = c_ok && f_acc(D_OPCODE) && !m_kill;
            chk("c_opcode", {15'd0, C_OPCODE}, {15'd0, exp_c});
            chk("d_ready", {31'd0, D_READY}, {31'd0, exp_rdy});
            chk("d_reject", {31'd0, D_REJECT}, {31'd0, D_VALID && !HOLD && !f_acc(exp_c)});
            if (exp_rdy) begin
                ni = '{pc: D_PC, op: D_OPCODE, rd: D_RD, rs1: D_RS1, rs2: D_RS2,
                       imm: D_IMM, cyc: cyc, alive: 1'b1};
                q.push_back(ni);
            end

            cur_w_en   = nxt_w_en;
            cur_w_rd   = nxt_w_rd;
            cur_w_data = nxt_w_data;
            cur_x_en   = nxt_x_en;
            cur_x_pc   = nxt_x_pc;
            cur_err    = nxt_err;
        end
    end

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] d; } wlog_t;
    wlog_t w_log[$];
    wlog_t x_log[$];
    always @(negedge CLK) begin
        if (W_EN) w_log.push_back('{cyc: cyc, rd: W_RD, d: W_DATA});
        if (X_EN) x_log.push_back('{cyc: cyc, rd: {1'b0, X_CODE}, d: X_PC});
    end

    logic [31:0] pc_ctr = 32'd0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ins(input logic v, input logic [16:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        D_VALID  = v;
        D_OPCODE = op;
        D_RD     = rd;
        D_RS1    = rs1;
        D_RS2    = rs2;
        D_IMM    = imm;
        D_PC     = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
    endtask

    task automatic idle();
        HOLD  = 1'b0;
        FLUSH = 1'b0;
        set_ins(1'b0, 17'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    endtask

    int t0;
    int r;

    initial begin
        RST = 1'b0;
        idle();
        repeat (3) tick();
        chk("lit_rst_w_en", {31'd0, W_EN}, 32'd0);
        chk("lit_rst_r_opcode", {15'd0, R_OPCODE}, 32'd0);
        chk("lit_rst_e_pc", E_PC, 32'd0);
        chk("lit_rst_err", {31'd0, ERR}, 32'd0);
        RST = 1'b1;

        // addi x1,x0,5 ; add x2,x1,x1 ; add x3,x2,x1 back to back
        tick();
        set_ins(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        #1 chk("lit_t1_ready", {31'd0, D_READY}, 32'd1);
        t0 = cyc;
        tick();
        set_ins(1'b1, OP_ADD, 5'd2, 5'd1, 5'd1, 32'd0);
        tick();
        set_ins(1'b1, OP_ADD, 5'd3, 5'd2, 5'd1, 32'd0);
        tick();
        idle();
        repeat (5) tick();
        chk("lit_t2_wcount", w_log.size(), 32'd3);
        for (int i = 0; i < w_log.size() && i < 3; i++) begin
            chk("lit_t2_wcyc", w_log[i].cyc, t0 + 3 + i);
            chk("lit_t2_wrd", {27'd0, w_log[i].rd}, i + 1);
            chk("lit_t2_wdata", w_log[i].d, 5 * (i + 1));
        end
        chk("lit_t2_err", {31'd0, ERR}, 32'd0);

        // unimplemented load is refused
        w_log.delete();
        tick();
        set_ins(1'b1, OP_LOAD, 5'd4, 5'd1, 5'd0, 32'd0);
        #1 chk("lit_t3_reject", {31'd0, D_REJECT}, 32'd1);
        chk("lit_t3_ready", {31'd0, D_READY}, 32'd0);
        tick();
        idle();
        repeat (4) tick();
        chk("lit_t3_wcount", w_log.size(), 32'd0);

        // trap squashes the younger Ready instruction and blocks the concurrent issue
        w_log.delete();
        x_log.delete();
        pc_ctr = 32'h100;
        tick();
        set_ins(1'b1, OP_TRAP, 5'd4, 5'd1, 5'd2, 32'd0);
        tick();
        set_ins(1'b1, OP_ADDI, 5'd5, 5'd0, 5'd0, 32'd7);
        tick();
        set_ins(1'b1, OP_ADDI, 5'd6, 5'd0, 5'd0, 32'd9);
        #1 chk("lit_t6_kill_ready", {31'd0, D_READY}, 32'd0);
        tick();
        idle();
        repeat (4) tick();
        chk("lit_t6_xcount", x_log.size(), 32'd1);
        if (x_log.size() > 0) begin
            chk("lit_t6_xpc", x_log[0].d, 32'h100);
            chk("lit_t6_xcode", {27'd0, x_log[0].rd}, 32'd2);
        end
        chk("lit_t6_wcount", w_log.size(), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i == 1500) RST = 1'b0;
            if (i == 1503) RST = 1'b1;
            HOLD  = $urandom_range(0, 99) < 10;
            FLUSH = $urandom_range(0, 99) < 4;
            r = $urandom_range(0, 99);
            set_ins($urandom_range(0, 99) < 85,
                    (r < 45) ? {OP_ADDI[16:7], 7'($urandom)} :
                    (r < 85) ? OP_ADD : (r < 90) ? OP_TRAP : OP_LOAD,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom);
        end
        tick();
        idle();
        repeat (4) tick();
        chk("lit_err_before_drop", {31'd0, ERR}, 32'd0);

        // cop drops an allowed instruction: ERR must rise and stay
        drop = 1'b1;
        set_ins(1'b1, OP_ADDI, 5'd7, 5'd0, 5'd0, 32'd3);
        tick();
        idle();
        repeat (3) tick();
        chk("lit_err_set", {31'd0, ERR}, 32'd1);
        repeat (5) tick();
        chk("lit_err_held", {31'd0, ERR}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
